// File: rtl/gb_camera_capture.sv
// Game Boy Camera capture engine: CAM register file, exposure countdown,
// 128x112 sensor readout, 4x4 dither quantisation and 2bpp tile writes.
module gb_camera_capture #(
  parameter int          IMG_W     = 128,
  parameter int          IMG_H     = 112,
  parameter logic [12:0] TILE_BASE = 13'h0100,
  parameter int          BUSY_BASE = 32768,
  parameter int          EXP_SHIFT = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic        cam_en,
  input  logic [15:0] cart_addr,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  output logic [7:0]  reg_do,
  output logic        busy,
  output logic [13:0] pix_addr,
  input  logic [7:0]  pix_data,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_ready
);

  localparam int NREG = 54;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPOSE = 3'd1,
    S_FETCH  = 3'd2,
    S_WR_LO  = 3'd3,
    S_WR_HI  = 3'd4
  } state_e;

  state_e      state_q;
  logic [7:0]  regs_q [NREG];
  logic [31:0] exp_cnt_q;
  logic [7:0]  x_q, y_q;
  logic [3:0]  fcnt_q;
  logic [7:0]  lo_q, hi_q;
  logic        busy_q, ram_we_q;
  logic [12:0] ram_addr_q;
  logic [7:0]  ram_data_q;
  logic [13:0] pix_addr_q;

  logic        sel_s, reg_wr_s, start_s, abort_s;
  logic [6:0]  idx_s;
  logic [1:0]  col_s, sum_s, level_s;
  logic [5:0]  m_s;
  logic [7:0]  t0_s, t1_s, t2_s, lo_d, hi_d, nx_d, ny_d;
  logic [12:0] tile_s, addr_lo_s;
  logic [13:0] base_d;
  logic [31:0] exp_load_s;
  logic        last_s, wrap_s;
  logic        unused_addr_s;

  assign busy     = busy_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign pix_addr = pix_addr_q;
  assign unused_addr_s = ^cart_addr[12:7];

  // CPU bus decode, trigger/abort detection and status readback
  always_comb begin
    sel_s    = cam_en & (cart_addr[15:13] == 3'b101);
    idx_s    = cart_addr[6:0];
    reg_wr_s = ce_cpu & cart_wr & sel_s & (idx_s < 7'd54);
    start_s  = reg_wr_s & (idx_s == 7'd0) & cart_di[0] & (state_q == S_IDLE);
    abort_s  = reg_wr_s & (idx_s == 7'd0) & ~cart_di[0] & (state_q != S_IDLE);
    if (sel_s && (idx_s == 7'd0)) begin
      reg_do = {5'b00000, regs_q[0][2:1], busy_q};
    end else begin
      reg_do = 8'h00;
    end
  end

  // Dither threshold lookup, tile addressing and next pixel-group position
  always_comb begin
    col_s      = 2'(fcnt_q - 4'd1);
    m_s        = 6'({y_q[1:0], col_s}) * 6'd3;
    t0_s       = regs_q[6'd6 + m_s];
    t1_s       = regs_q[6'd7 + m_s];
    t2_s       = regs_q[6'd8 + m_s];
    sum_s      = {1'b0, (pix_data >= t0_s)} + {1'b0, (pix_data >= t1_s)}
               + {1'b0, (pix_data >= t2_s)};
    level_s    = 2'd3 - sum_s;
    lo_d       = {lo_q[6:0], level_s[0]};
    hi_d       = {hi_q[6:0], level_s[1]};
    tile_s     = 13'(y_q >> 3) * 13'(IMG_W / 8) + 13'(x_q >> 3);
    addr_lo_s  = TILE_BASE + {tile_s[8:0], 4'b0000} + {9'b000000000, y_q[2:0], 1'b0};
    wrap_s     = (x_q == 8'(IMG_W - 8));
    last_s     = wrap_s & (y_q == 8'(IMG_H - 1));
    if (wrap_s) begin
      nx_d = 8'd0;
      ny_d = y_q + 8'd1;
    end else begin
      nx_d = x_q + 8'd8;
      ny_d = y_q;
    end
    base_d     = 14'(ny_d) * 14'(IMG_W) + 14'(nx_d);
    exp_load_s = 32'(BUSY_BASE) + ({16'h0000, regs_q[2], regs_q[3]} << EXP_SHIFT);
  end

  // Register file and capture state machine with registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      state_q <= S_IDLE;  exp_cnt_q <= 32'd0;
      x_q <= 8'd0;  y_q <= 8'd0;  fcnt_q <= 4'd0;
      lo_q <= 8'h00;  hi_q <= 8'h00;
      busy_q <= 1'b0;  ram_we_q <= 1'b0;
      ram_addr_q <= 13'd0;  ram_data_q <= 8'h00;  pix_addr_q <= 14'd0;
    end else if (!enable) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
      state_q <= S_IDLE;  exp_cnt_q <= 32'd0;
      x_q <= 8'd0;  y_q <= 8'd0;  fcnt_q <= 4'd0;
      lo_q <= 8'h00;  hi_q <= 8'h00;
      busy_q <= 1'b0;  ram_we_q <= 1'b0;
      ram_addr_q <= 13'd0;  ram_data_q <= 8'h00;  pix_addr_q <= 14'd0;
    end else begin
      if (reg_wr_s) regs_q[idx_s[5:0]] <= cart_di;
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            state_q   <= S_EXPOSE;
            busy_q    <= 1'b1;
            exp_cnt_q <= exp_load_s;
          end
        end
        S_EXPOSE: begin
          if (exp_cnt_q == 32'd0) begin
            state_q    <= S_FETCH;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            fcnt_q     <= 4'd0;
            pix_addr_q <= 14'd0;
          end else if (ce_cpu) begin
            exp_cnt_q <= exp_cnt_q - 32'd1;
          end
        end
        S_FETCH: begin
          // pixel j-1 of the group arrives while fcnt_q == j (1-cycle source latency)
          fcnt_q <= fcnt_q + 4'd1;
          if (fcnt_q < 4'd7) pix_addr_q <= pix_addr_q + 14'd1;
          if (fcnt_q != 4'd0) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
          end
          if (fcnt_q == 4'd8) begin
            state_q    <= S_WR_LO;
            ram_we_q   <= 1'b1;
            ram_addr_q <= addr_lo_s;
            ram_data_q <= lo_d;
          end
        end
        S_WR_LO: begin
          if (ram_ready) begin
            state_q    <= S_WR_HI;
            ram_addr_q <= ram_addr_q + 13'd1;
            ram_data_q <= hi_q;
          end
        end
        S_WR_HI: begin
          if (ram_ready) begin
            ram_we_q <= 1'b0;
            if (last_s) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              regs_q[0][0] <= 1'b0;
            end else begin
              state_q    <= S_FETCH;
              fcnt_q     <= 4'd0;
              x_q        <= nx_d;
              y_q        <= ny_d;
              pix_addr_q <= base_d;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
      if (abort_s) begin
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        ram_we_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gb_camera_capture.sv
// Self-checking bench for gb_camera_capture on a reduced 32x16 frame.
module tb_gb_camera_capture;

  localparam int W  = 32;
  localparam int H  = 16;
  localparam int NB = (W / 8) * (H / 8) * 16;
  localparam int BB = 40;

  logic        clk_sys = 1'b0, reset_n = 1'b0, enable = 1'b0, ce_cpu = 1'b0;
  logic        cam_en = 1'b0, cart_wr = 1'b0, ram_ready = 1'b0;
  logic [15:0] cart_addr = 16'h0000;
  logic [7:0]  cart_di = 8'h00, pix_data = 8'h00;
  logic [7:0]  reg_do, ram_data;
  logic        busy, ram_we;
  logic [13:0] pix_addr;
  logic [12:0] ram_addr;

  always #5 clk_sys = ~clk_sys;

  gb_camera_capture #(.IMG_W(W), .IMG_H(H), .TILE_BASE(13'h0100),
                      .BUSY_BASE(BB), .EXP_SHIFT(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .ce_cpu(ce_cpu),
    .cam_en(cam_en), .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di),
    .reg_do(reg_do), .busy(busy), .pix_addr(pix_addr), .pix_data(pix_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ready(ram_ready)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0]  frame [0:W*H-1];
  logic [7:0]  regs_m [0:53];
  logic [7:0]  mem_b [0:NB-1];
  logic [7:0]  exp_b [0:NB-1];
  int          wcount = 0, oob = 0, stall_n = 0, ready_pct = 70;
  logic [12:0] first_addr = 13'd0, last_addr = 13'd0;
  bit          ce_rand = 1'b0, stall_first = 1'b0, hs_en = 1'b0, last_acc = 1'b0;
  bit          hold_pend = 1'b0;
  logic [12:0] hold_a = 13'd0;
  logic [7:0]  hold_d = 8'h00;
  int          ce_hist [0:4095];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sensor model: data for the address seen one clock earlier
  always @(posedge clk_sys) pix_data <= frame[pix_addr[8:0]];

  // Cart RAM model: record accepted writes
  always @(posedge clk_sys) begin
    if (ram_we && ram_ready) begin
      if (wcount == 0) first_addr = ram_addr;
      last_addr = ram_addr;
      if (ram_addr >= 13'h0100 && ram_addr < 13'(13'h0100 + NB)) mem_b[ram_addr - 13'h0100] = ram_data;
      else oob++;
      wcount++;
      if (wcount == NB) last_acc = 1'b1;
    end
  end

  // Handshake monitor: an un-accepted write must be held unchanged
  always @(posedge clk_sys) begin
    if (hs_en && hold_pend) check("hold", {ram_we, ram_addr, ram_data}, {1'b1, hold_a, hold_d});
    hold_pend = hs_en && ram_we && !ram_ready;
    hold_a = ram_addr;
    hold_d = ram_data;
  end

  // Completion: busy must already be low after the last accepted write
  always @(negedge clk_sys) begin
    if (last_acc) begin
      check("busy_fall", busy, 1'b0);
      last_acc = 1'b0;
    end
  end

  // RAM ready driver with optional 5-cycle stall on the first write
  always @(negedge clk_sys) begin
    if (stall_first && wcount == 0 && ram_we && stall_n < 5) begin
      ram_ready = 1'b0;
      stall_n++;
      check("stall_hold", {ram_we, ram_addr}, {1'b1, 13'h0100});
    end else begin
      ram_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    cart_wr = 1'b0;
    ce_cpu = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cam_en = 1'b1;  cart_addr = a;  cart_di = d;  cart_wr = 1'b1;  ce_cpu = 1'b1;
    if (a[15:13] == 3'b101 && a[6:0] < 7'd54) regs_m[a[6:0]] = d;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] e);
    @(negedge clk_sys);
    cam_en = 1'b1;  cart_addr = a;  cart_wr = 1'b0;
    #1 check(tag, reg_do, e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 54; i++) regs_m[i] = 8'h00;
  endtask

  task automatic set_thr(input int mode);
    for (int i = 6; i < 54; i++) begin
      case (mode)
        0: wr(16'hA000 + 16'(i), 8'h80);
        1: wr(16'hA000 + 16'(i), (i % 3 == 0) ? 8'h40 : ((i % 3 == 1) ? 8'h80 : 8'hC0));
        default: wr(16'hA000 + 16'(i), 8'($urandom));
      endcase
    end
  endtask

  task automatic fill_frame(input int mode, input logic [7:0] v);
    for (int i = 0; i < W * H; i++) frame[i] = (mode == 0) ? v : 8'($urandom);
  endtask

  // Reference: expected tile bytes from frame and thresholds
  task automatic build_model();
    for (int ty = 0; ty < H / 8; ty++)
      for (int tx = 0; tx < W / 8; tx++)
        for (int r = 0; r < 8; r++)
          for (int pl = 0; pl < 2; pl++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int c = 0; c < 8; c++) begin
              int x, y, m, cnt, lvl;
              logic [7:0] p;
              x = tx * 8 + c;  y = ty * 8 + r;
              p = frame[y * W + x];
              m = ((y % 4) * 4 + (x % 4)) * 3;
              cnt = int'(p >= regs_m[6 + m]) + int'(p >= regs_m[7 + m]) + int'(p >= regs_m[8 + m]);
              lvl = 3 - cnt;
              b[7 - c] = (pl == 0) ? lvl[0] : lvl[1];
            end
            exp_b[(ty * (W / 8) + tx) * 16 + r * 2 + pl] = b;
          end
  endtask

  task automatic start_capture(input logic [7:0] reg0);
    build_model();
    for (int i = 0; i < NB; i++) mem_b[i] = 8'h5A;
    wcount = 0;  oob = 0;  hs_en = 1'b1;
    wr(16'hA000, reg0);
  endtask

  task automatic measure_exposure();
    int k, sum_all, sum_pre, n_exp;
    bit seen;
    n_exp = BB + (int'({regs_m[2], regs_m[3]}) << 4);
    k = 0;  seen = 1'b0;
    while (!seen && k < 4000) begin
      ce_hist[k + 1] = int'(ce_cpu);
      @(posedge clk_sys);
      #1 k++;
      if (k == 1) check("reg0_busy", reg_do, 8'h05);
      if (pix_addr != 14'd0) seen = 1'b1;
      else begin
        @(negedge clk_sys);
        ce_cpu = 1'($urandom_range(0, 1));
      end
    end
    check("exp_seen", seen, 1'b1);
    sum_all = 0;  sum_pre = 0;
    for (int i = 1; i <= k - 2; i++) sum_all += ce_hist[i];
    for (int i = 1; i <= k - 3; i++) sum_pre += ce_hist[i];
    check("exp_ticks", sum_all, n_exp);
    check("exp_ticks_pre", sum_pre, n_exp - 1);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (busy && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("done_timeout", busy, 1'b0);
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, wcount, NB);
    check({tag, "_oob"}, oob, 0);
    check({tag, "_first"}, first_addr, 13'h0100);
    check({tag, "_last"}, last_addr, 13'(13'h0100 + NB - 1));
    for (int i = 0; i < NB; i++) check({tag, "_byte"}, {i[15:0], mem_b[i]}, {i[15:0], exp_b[i]});
    rd_chk({tag, "_reg0"}, 16'hA000, {5'b00000, regs_m[0][2:1], 1'b0});
    hs_en = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int cyc;
    cyc = 0;
    while (wcount < n && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("wait_writes", wcount >= n, 1'b1);
  endtask

  initial begin
    int w0;
    bit we_seen;
    clear_model();
    cam_en = 1'b1;  cart_addr = 16'hA000;
    repeat (3) @(negedge clk_sys);
    #1 check("rst_outputs", {reg_do, busy, ram_we, ram_addr, ram_data, pix_addr}, 44'h0);
    reset_n = 1'b1;  enable = 1'b1;
    rd_chk("idle_reg0", 16'hA000, 8'h00);
    check("idle_busy", busy, 1'b0);

    // Decode: mirror every 0x80, index >= 0x36 ignored, other indices read 0
    wr(16'hA080, 8'h06);
    rd_chk("mirror_rd", 16'hA000, 8'h06);
    rd_chk("mirror_rd80", 16'hA080, 8'h06);
    rd_chk("idx1_rd", 16'hA001, 8'h00);
    wr(16'hA040, 8'h00);
    wr(16'hA036, 8'h00);
    rd_chk("idx_oor", 16'hA000, 8'h06);
    @(negedge clk_sys) cam_en = 1'b0;
    #1 check("camen_off", reg_do, 8'h00);
    @(negedge clk_sys) enable = 1'b0;
    @(negedge clk_sys) enable = 1'b1;
    clear_model();
    rd_chk("enable_clr", 16'hA000, 8'h00);

    // Exposure timing plus all-0xFF frame with 0x80 thresholds
    ce_rand = 1'b1;
    set_thr(0);
    wr(16'hA002, 8'h00);
    wr(16'hA003, 8'h02);
    fill_frame(0, 8'hFF);
    start_capture(8'h05);
    measure_exposure();
    wait_done();
    verify("ff");

    fill_frame(0, 8'h00);
    start_capture(8'h05);  wait_done();  verify("zero");
    check("zero_b0", mem_b[0], 8'hFF);

    set_thr(1);
    fill_frame(0, 8'h90);
    start_capture(8'h05);  wait_done();  verify("lvl1");
    check("lvl1_lo", mem_b[0], 8'hFF);
    check("lvl1_hi", mem_b[1], 8'h00);

    // First write stalled for 5 cycles
    set_thr(2);
    fill_frame(1, 8'h00);
    stall_first = 1'b1;  stall_n = 0;
    start_capture(8'h03);  wait_done();  verify("stall");
    check("stall_cycles", stall_n, 5);
    stall_first = 1'b0;

    // Random frames, thresholds and exposures
    for (int f = 0; f < 4; f++) begin
      set_thr(2);
      wr(16'hA003, 8'($urandom_range(0, 15)));
      fill_frame(1, 8'h00);
      ready_pct = 40 + 15 * f;
      start_capture({5'b00000, 2'($urandom_range(0, 3)), 1'b1});
      wait_done();
      verify("rand");
    end
    ready_pct = 70;

    // Abort after 100 accepted writes
    fill_frame(1, 8'h00);
    start_capture(8'h01);
    wait_writes(100);
    hs_en = 1'b0;
    wr(16'hA000, 8'h00);
    check("abort_busy", {busy, ram_we}, 2'b00);
    w0 = wcount;  we_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ram_we) we_seen = 1'b1;
    end
    check("abort_count", wcount, w0);
    check("abort_we", we_seen, 1'b0);

    // Retrigger while busy: no restart, bits 2:1 still update
    start_capture(8'h01);
    wait_writes(20);
    wr(16'hA000, 8'h03);
    rd_chk("rewrite_reg0", 16'hA000, 8'h03);
    wait_done();
    verify("rewrite");

    // Asynchronous reset in the middle of conversion
    start_capture(8'h05);
    wait_writes(10);
    hs_en = 1'b0;
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1 check("async_rst", {reg_do, busy, ram_we, ram_addr, ram_data, pix_addr}, 44'h0);
    @(negedge clk_sys) reset_n = 1'b1;
    clear_model();
    w0 = wcount;
    for (int i = 0; i < 30; i++) tick();
    check("rst_nowrite", wcount, w0);
    rd_chk("rst_reg0", 16'hA000, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_camera_capture.md
Name: gb_camera_capture

Overview:
Capture engine for the Game Boy Camera mapper. Owns the 0x36-byte CAM register file in the 0xA000-0xBFFF window while the mapper has CAM registers selected. On a trigger it runs a programmable exposure countdown, then reads a 128x112 8-bit sensor frame. Each pixel is quantised through a 4x4 dither/threshold matrix, and the result is written into cart RAM bank 0 at 0x0100-0x0EFF as Game Boy 2bpp tiles.

Parameters:
IMG_W, 128, image width in pixels; must be a multiple of 8.
IMG_H, 112, image height in pixels; must be a multiple of 8.
TILE_BASE, 13'h0100, cart RAM byte offset of tile 0.
BUSY_BASE, 32768, fixed exposure overhead in ce_cpu ticks.
EXP_SHIFT, 4, left shift applied to the 16-bit exposure value.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  camera mapper selected; low = synchronous return to idle, registers cleared.
ce_cpu  in  1  CPU clock enable; qualifies bus writes and exposure counting.
cam_en  in  1  mapper CAM-register select (RAM bank reg bit 4).
cart_addr  in  16  CPU address.
cart_wr  in  1  CPU write strobe.
cart_di  in  8  CPU write data.
reg_do  out  8  register read data for the 0xA000-0xBFFF window when cam_en.
busy  out  1  capture in progress (exposure or conversion).
pix_addr  out  14  sensor frame address, y*IMG_W+x.
pix_data  in  8  sensor pixel, valid one clk_sys after pix_addr changes.
ram_we  out  1  cart RAM write request; has priority over the CPU at the RAM mux.
ram_addr  out  13  cart RAM byte address, bank 0.
ram_data  out  8  cart RAM write data.
ram_ready  in  1  RAM accepted the write this cycle.

Behaviour:
- Reset (async, reset_n low): all registers 0x00; state IDLE; busy=0, ram_we=0, ram_addr=0, ram_data=0, pix_addr=0, reg_do=0x00.
- Register decode: cam_en & cart_addr[15:13]==3'b101. Index = cart_addr[6:0], so registers mirror every 0x80. Writes with index >= 0x36 are ignored.
- Writes take effect on ce_cpu & cart_wr.
- reg_do: index 0 returns {5'b0, reg0[2:1], busy}. All other indices return 0x00. reg_do is combinational.
- Trigger: writing reg0 with bit0=1 in IDLE enters EXPOSE.
  - Exposure counter loads BUSY_BASE + ({reg2,reg3} << EXP_SHIFT) (32 bits) and decrements on each ce_cpu.
  - Writing bit0=1 while busy is ignored; bits 2:1 still update.
  - Writing bit0=0 while busy aborts: the state machine returns to IDLE next clk_sys, ram_we drops, and bytes already written stay in RAM.
- States:
  - IDLE.
  - EXPOSE: counter reaches 0 -> FETCH with x=0, y=0.
  - FETCH: 8 consecutive pixels x..x+7 of row y, one per clk_sys; the pipeline accounts for the 1-cycle pix_data latency.
  - WR_LO, then WR_HI.
  - Next pixel group advances x by 8. x wraps to 0 with y+1. After the last group, y==IMG_H-1 and x==IMG_W-8 -> IDLE.
- Quantisation for pixel (x,y):
  - m = ((y&3)*4 + (x&3))*3.
  - t0, t1, t2 = reg[6+m], reg[7+m], reg[8+m].
  - level = 3 - ((p>=t0) + (p>=t1) + (p>=t2)), 2 bits; p = pix_data.
  - Bit 7 of each plane byte is the leftmost pixel. lo plane = level[0], hi plane = level[1].
- Tile address: ram_addr = TILE_BASE + (((y>>3)*(IMG_W/8) + (x>>3))<<4) + ((y&7)<<1) + plane; plane 0 = lo, plane 1 = hi.
  - Defaults give 0x0100..0x0EFF, 3584 bytes.
- Write handshake: ram_we, ram_addr and ram_data are held stable until the cycle ram_ready=1. The state advances on that cycle. ram_we may drop or stay high the following cycle only for the next byte.
- Completion: busy falls, and reg0 bit0 reads 0, in the same cycle the last hi-plane write is accepted.
- enable low at any time: same as reset, but synchronous.
- Register writes during FETCH/WR affect thresholds immediately; no shadowing.

Test Plan:
1. Reset then read 0xA000 -> reg_do=0x00, busy=0. Write 0xA000=0x05 -> next read 0x05. busy stays high for BUSY_BASE+(reg2:3<<4) ce_cpu ticks, then conversion starts.
2. reg2=reg3=0, all thresholds 0x80, frame all 0xFF -> 3584 writes, every byte 0x00, first ram_addr 0x0100, last 0x0EFF. Then busy=0 and 0xA000 reads 0x04.
3. Same thresholds, frame all 0x00 -> every byte 0xFF. Thresholds 0x40/0x80/0xC0 with pixel 0x90 -> level 1, so lo=0xFF, hi=0x00.
4. Hold ram_ready low for 5 cycles on the first write -> ram_we, ram_addr=0x0100 and ram_data held unchanged. Total write count is still 3584.
5. Abort: write 0xA000=0x00 after 100 accepted writes -> busy=0 within 1 clk_sys, no further ram_we. Writing 0x01 while busy -> no restart and the count is unaffected.
6. Assert reset_n low mid-FETCH, asynchronously -> all outputs 0 immediately. Index 0x36 and mirror 0xA080 -> write to 0x36 ignored; write to 0xA080 aliases reg0.
